// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU.
//   op_e      : 3-bit opcode encoding
//   state_e   : IDLE/RUN controller states
//   cnt_width : width of the bit-cycle counter for a given operand width
package serial_alu_pkg;

  typedef enum logic [2:0] {
    OP_NOR  = 3'b000,
    OP_ADD  = 3'b001,
    OP_XNOR = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_CMP  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_alu_bitcell.sv
// One bit-slice of the serial ALU, evaluated once per bit-cycle.
// Ports:
//   a, b      : operand bits for the current position
//   carry_in  : carry (ADD) or borrow (SUB/CMP) from the previous bit
//   op        : latched opcode
//   r         : result bit
//   carry_out : carry/borrow to the next bit (0 for logical ops)
module serial_alu_bitcell
  import serial_alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic carry_in,
  input  op_e  op,
  output logic r,
  output logic carry_out
);

  always_comb begin
    r         = 1'b0;
    carry_out = 1'b0;
    case (op)
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_ADD: begin
        r         = a ^ b ^ carry_in;
        carry_out = (a & b) | (a & carry_in) | (b & carry_in);
      end
      // CMP shares the subtract chain; the top decides what to keep.
      OP_SUB, OP_CMP: begin
        r         = a ^ b ^ carry_in;
        carry_out = (~a & b) | (~a & carry_in) | (b & carry_in);
      end
      default: begin
        r         = 1'b0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: one result bit per clock, LSB first, WIDTH cycles per op.
// Optional feature macro: SERIAL_ALU_CMP_EN enables op 111 (signed compare);
// without it op 111 runs the full length and returns zero.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, op, src_a/b    : request, opcode and operands (sampled in IDLE)
//   abort                 : cancel the operation in flight
//   busy, done            : operation in progress / one-cycle completion pulse
//   result, zero, carry,
//   sign, overflow        : result and flags, held until the next completion
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state, state_nxt;
  op_e              op_q;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] acc;
  logic             carry_q;
  logic             bit_r, bit_co;
  logic             last_bit, load, step, complete;
  logic [WIDTH-1:0] full;
  logic             arith_ovf;
  logic [WIDTH-1:0] fin_result;
  logic             fin_carry, fin_ovf;

  serial_alu_bitcell u_cell (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .carry_in  (carry_q),
    .op        (op_q),
    .r         (bit_r),
    .carry_out (bit_co)
  );

  assign last_bit = (count == CW'(WIDTH - 1));
  assign load     = (state == ST_IDLE) && start;
  assign step     = (state == ST_RUN) && !abort;
  assign complete = step && last_bit;
  assign busy     = (state == ST_RUN);

  // The newest bit enters at the top, so after WIDTH steps the word is aligned.
  assign full      = {bit_r, acc};
  // Signed overflow of the MSB is carry-into xor carry-out (same for borrows).
  assign arith_ovf = carry_q ^ bit_co;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Abort wins over the final bit so an aborted op never completes.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (abort || last_bit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand shift registers, partial result and carry/borrow chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_NOR;
      a_sr    <= '0;
      b_sr    <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      count   <= '0;
    end else if (load) begin
      op_q    <= op_e'(op);
      a_sr    <= src_a;
      b_sr    <= src_b;
      acc     <= '0;
      carry_q <= 1'b0;
      count   <= '0;
    end else if (step) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      acc     <= full[WIDTH-1:1];
      carry_q <= bit_co;
      count   <= count + 1'b1;
    end else if (state == ST_RUN) begin
      count   <= '0;
    end
  end

  // Final result and flag selection from the last bit-cycle.
  always_comb begin
    fin_result = full;
    fin_carry  = 1'b0;
    fin_ovf    = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        fin_carry = bit_co;
        fin_ovf   = arith_ovf;
      end
      OP_CMP: begin
`ifdef SERIAL_ALU_CMP_EN
        fin_result    = '0;
        fin_result[0] = full[WIDTH-1] ^ arith_ovf;
        fin_carry     = bit_co;
`else
        fin_result = '0;
`endif
      end
      default: ;
    endcase
  end

  // Visible outputs only change at completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      carry    <= 1'b0;
      sign     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= complete;
      if (complete) begin
        result   <= fin_result;
        zero     <= (fin_result == '0);
        carry    <= fin_carry;
        sign     <= fin_result[WIDTH-1];
        overflow <= fin_ovf;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Directed self-checking bench for serial_alu at WIDTH=8.
module tb_serial_alu;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [2:0] op;
  logic [7:0] src_a, src_b;
  logic       busy, done;
  logic [7:0] result;
  logic       zero, carry, sign, overflow;

  int total = 0;
  int bad   = 0;

  serial_alu #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .sign     (sign),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Drive one start request; returns at the falling edge after the sampling edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; cycles counts falling edges since the sampling edge.
  task automatic waitDone(output int cycles);
    cycles = 1;
    while (done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    total++; if ({result, zero, carry, sign, overflow} !== {8'h00, 4'b1000})
      begin bad++; $display("[TB] FAIL reset_outputs got=%h/%b%b%b%b want=00/1000", result, zero, carry, sign, overflow); end
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL start_in_reset got=%b want=0", busy); end
    start = 1'b0; reset = 1'b0;
  endtask

  task automatic test_add_overflow();
    int c;
    applyStimulus(3'b001, 8'h7F, 8'h01);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL add_busy got=%b want=1", busy); end
    waitDone(c);
    total++; if (c !== 9) begin bad++; $display("[TB] FAIL add_latency got=%0d want=9", c); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL add_busy_end got=%b want=0", busy); end
    total++; if ({result, zero, carry, sign, overflow} !== {8'h80, 4'b0011})
      begin bad++; $display("[TB] FAIL add_7f_01 got=%h/%b%b%b%b want=80/0011", result, zero, carry, sign, overflow); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL done_one_cycle got=%b want=0", done); end
  endtask

  task automatic test_back_to_back();
    int c;
    applyStimulus(3'b011, 8'h05, 8'h07);
    waitDone(c);
    total++; if (c !== 9) begin bad++; $display("[TB] FAIL sub_latency got=%0d want=9", c); end
    total++; if ({result, zero, carry, sign, overflow} !== {8'hFE, 4'b0110})
      begin bad++; $display("[TB] FAIL sub_05_07 got=%h/%b%b%b%b want=fe/0110", result, zero, carry, sign, overflow); end
    start = 1'b1; op = 3'b000; src_a = 8'h00; src_b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy got=%b want=1", busy); end
    total++; if (result !== 8'hFE) begin bad++; $display("[TB] FAIL held_in_run got=%h want=fe", result); end
    waitDone(c);
    total++; if (c !== 9) begin bad++; $display("[TB] FAIL nor_latency got=%0d want=9", c); end
    total++; if ({result, zero, carry, sign, overflow} !== {8'hFF, 4'b0010})
      begin bad++; $display("[TB] FAIL nor_00_00 got=%h/%b%b%b%b want=ff/0010", result, zero, carry, sign, overflow); end
  endtask

  task automatic test_add_wrap();
    int c;
    applyStimulus(3'b001, 8'hFF, 8'h01);
    waitDone(c);
    total++; if (c !== 9) begin bad++; $display("[TB] FAIL wrap_latency got=%0d want=9", c); end
    total++; if ({result, zero, carry, sign, overflow} !== {8'h00, 4'b1100})
      begin bad++; $display("[TB] FAIL add_ff_01 got=%h/%b%b%b%b want=00/1100", result, zero, carry, sign, overflow); end
  endtask

  task automatic test_ops_table();
    // op, a, b, expected result, expected {zero,carry,sign,overflow}
    logic [2:0] ops  [6] = '{3'b100, 3'b101, 3'b110, 3'b010, 3'b000, 3'b011};
    logic [7:0] as   [6] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h80};
    logic [7:0] bs   [6] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h01};
    logic [7:0] exp  [6] = '{8'h24, 8'hBD, 8'h99, 8'h66, 8'h42, 8'h7F};
    logic [3:0] flg  [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0001};
    int c;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(ops[i], as[i], bs[i]);
      waitDone(c);
      total++;
      if ({result, zero, carry, sign, overflow} !== {exp[i], flg[i]})
        begin bad++; $display("[TB] FAIL op%0d got=%h/%b%b%b%b want=%h/%b", ops[i], result, zero, carry, sign, overflow, exp[i], flg[i]); end
    end
  endtask

  task automatic test_abort();
    logic seen = 1'b0;
    int c;
    // Previous completion was SUB 80-01 = 7F with overflow.
    applyStimulus(3'b001, 8'h11, 8'h22);
    @(negedge clk); seen |= done;
    @(negedge clk); seen |= done;
    start = 1'b1; src_a = 8'h40; src_b = 8'h40;
    @(negedge clk); seen |= done; start = 1'b0;
    @(negedge clk); seen |= done; abort = 1'b1;
    @(negedge clk); seen |= done; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
    @(negedge clk); seen |= done;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy_e6 got=%b want=0", busy); end
    for (int i = 0; i < 12; i++) begin @(negedge clk); seen |= done; end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL abort_no_done got=%b want=0", seen); end
    total++; if ({result, zero, carry, sign, overflow} !== {8'h7F, 4'b0001})
      begin bad++; $display("[TB] FAIL abort_held got=%h/%b%b%b%b want=7f/0001", result, zero, carry, sign, overflow); end
    // Abort while idle must not block a start in the same cycle.
    @(negedge clk); start = 1'b1; abort = 1'b1; op = 3'b100; src_a = 8'hF0; src_b = 8'h3C;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    waitDone(c);
    total++; if (c !== 9) begin bad++; $display("[TB] FAIL idle_abort_latency got=%0d want=9", c); end
    total++; if (result !== 8'h30) begin bad++; $display("[TB] FAIL idle_abort_and got=%h want=30", result); end
  endtask

  task automatic test_reset_mid_run();
    logic seen = 1'b0;
    applyStimulus(3'b001, 8'h01, 8'h02);
    @(negedge clk); @(negedge clk); @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy got=%b want=0", busy); end
    total++; if ({done, result, zero, carry, sign, overflow} !== {1'b0, 8'h00, 4'b1000})
      begin bad++; $display("[TB] FAIL midreset_outputs got=%b/%h/%b%b%b%b want=0/00/1000", done, result, zero, carry, sign, overflow); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; reset = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); seen |= done | busy; end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL midreset_quiet got=%b want=0", seen); end
  endtask

  task automatic test_cmp();
    int c;
    applyStimulus(3'b111, 8'hFE, 8'h01);
    waitDone(c);
    total++; if (c !== 9) begin bad++; $display("[TB] FAIL cmp_latency got=%0d want=9", c); end
`ifdef SERIAL_ALU_CMP_EN
    total++; if ({result, zero, carry, sign, overflow} !== {8'h01, 4'b0000})
      begin bad++; $display("[TB] FAIL cmp_fe_01 got=%h/%b%b%b%b want=01/0000", result, zero, carry, sign, overflow); end
`else
    total++; if ({result, zero, carry, sign, overflow} !== {8'h00, 4'b1000})
      begin bad++; $display("[TB] FAIL cmp_illegal got=%h/%b%b%b%b want=00/1000", result, zero, carry, sign, overflow); end
`endif
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_add_wrap();
    test_ops_table();
    test_abort();
    test_reset_mid_run();
    test_cmp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
